// File: rtl/rx78_pkg.sv
// Shared types and constants for the RX-78 ioctl upload path.
package rx78_pkg;

    typedef enum logic [1:0] {
        UP_IDLE  = 2'd0,
        UP_FETCH = 2'd1,
        UP_WAIT  = 2'd2
    } up_state_t;

    localparam logic [7:0] IDX_EXTRAM   = 8'd2;
    localparam int         EXTRAM_BYTES = 32768;

endpackage

// File: rtl/rx78_ioctl_uploader_if.sv
// HPS ioctl read channel: the HPS side is master, the uploader is slave.
interface rx78_ioctl_uploader_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        output ioctl_din, ioctl_wait
    );
endinterface

// File: rtl/rx78_edge_det.sv
// Rising-edge detector; INIT sets the assumed previous level out of reset
// so an inverted input does not fire a spurious edge after reset.
module rx78_edge_det #(
    parameter bit INIT = 1'b0
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic d,
    output logic rise
);
    logic d_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            d_reg <= INIT;
        end else begin
            d_reg <= d;
        end
    end

    assign rise = d & ~d_reg;
endmodule

// File: rtl/rx78_ioctl_uploader.sv
// Serves HPS ioctl byte reads from EXT RAM for .SAV upload and raises a
// one-shot upload request when the RAM image has been written.
module rx78_ioctl_uploader
    import rx78_pkg::*;
#(
    parameter logic [7:0] INDEX      = IDX_EXTRAM,
    parameter int         ADDR_W     = 15,
    parameter int         MEM_BYTES  = EXTRAM_BYTES,
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] FILL       = 8'hFF
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    rx78_ioctl_uploader_if.slave  ioctl,
    output logic                  ioctl_upload_req,
    input  logic                  save_trigger,
    input  logic                  mem_we_mon,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_q
);
    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY);

    up_state_t         state_reg;
    logic [2:0]        cnt_reg;
    logic [7:0]        din_reg;
    logic              wait_reg;
    logic              mem_rd_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              dirty_reg;
    logic              req_reg;
    logic              req_sent_reg;

    logic active;
    logic in_range;
    logic trig_rise;
    logic upload_end;
    logic req_fire;

    assign active   = ioctl.ioctl_upload & (ioctl.ioctl_index == INDEX);
    // Full 25-bit compare: addresses beyond the image never alias into RAM.
    assign in_range = ioctl.ioctl_addr < 25'(MEM_BYTES);

    rx78_edge_det #(.INIT(1'b0)) u_trig_edge (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .d       (save_trigger),
        .rise    (trig_rise)
    );

    rx78_edge_det #(.INIT(1'b1)) u_end_edge (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .d       (~active),
        .rise    (upload_end)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= UP_IDLE;
            cnt_reg      <= 3'd0;
            din_reg      <= 8'h00;
            wait_reg     <= 1'b0;
            mem_rd_reg   <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            mem_rd_reg <= 1'b0;
            case (state_reg)
                UP_IDLE: begin
                    if (active && ioctl.ioctl_rd) begin
                        if (in_range) begin
                            mem_addr_reg <= ioctl.ioctl_addr[ADDR_W-1:0];
                            mem_rd_reg   <= 1'b1;
                            wait_reg     <= 1'b1;
                            cnt_reg      <= CNT_INIT;
                            state_reg    <= UP_FETCH;
                        end else begin
                            din_reg <= FILL;
                        end
                    end
                end
                UP_FETCH: begin
                    if (!ioctl.ioctl_upload) begin
                        wait_reg  <= 1'b0;
                        state_reg <= UP_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                        if (cnt_reg == 3'd1) begin
                            state_reg <= UP_WAIT;
                        end
                    end
                end
                UP_WAIT: begin
                    // An aborted transfer leaves the previous byte on din.
                    if (ioctl.ioctl_upload) begin
                        din_reg <= mem_q;
                    end
                    wait_reg  <= 1'b0;
                    state_reg <= UP_IDLE;
                end
                default: begin
                    wait_reg  <= 1'b0;
                    state_reg <= UP_IDLE;
                end
            endcase
        end
    end

    // One request per dirty episode; re-armed only when a matching upload ends.
    assign req_fire = trig_rise & dirty_reg & ~ioctl.ioctl_upload & ~req_sent_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty_reg    <= 1'b0;
            req_reg      <= 1'b0;
            req_sent_reg <= 1'b0;
        end else begin
            dirty_reg <= mem_we_mon | (dirty_reg & ~upload_end);
            req_reg   <= req_fire;
            if (req_fire) begin
                req_sent_reg <= 1'b1;
            end else if (upload_end) begin
                req_sent_reg <= 1'b0;
            end
        end
    end

    assign ioctl.ioctl_din  = din_reg;
    assign ioctl.ioctl_wait = wait_reg;
    assign ioctl_upload_req = req_reg;
    assign mem_addr         = mem_addr_reg;
    assign mem_rd           = mem_rd_reg;
endmodule

// File: tb/tb_rx78_ioctl_uploader.sv
// Directed bench for rx78_ioctl_uploader with a 1-cycle-latency RAM model.
module tb_rx78_ioctl_uploader;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload_req;
    logic        save_trigger;
    logic        mem_we_mon;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_q;

    logic [7:0]  ram [0:32767];
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_pulses = 0;
    int          req_pulses = 0;

    rx78_ioctl_uploader_if bus ();

    rx78_ioctl_uploader dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .ioctl            (bus),
        .ioctl_upload_req (ioctl_upload_req),
        .save_trigger     (save_trigger),
        .mem_we_mon       (mem_we_mon),
        .mem_addr         (mem_addr),
        .mem_rd           (mem_rd),
        .mem_q            (mem_q)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_rd === 1'b1) begin
            mem_q     <= ram[mem_addr];
            rd_pulses <= rd_pulses + 1;
        end
        if (ioctl_upload_req === 1'b1) begin
            req_pulses <= req_pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // HPS model: strobe rd, then hold off while ioctl_wait is high (bounded).
    task automatic hps_read(input logic [24:0] a, output logic [7:0] d, output int stall);
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_rd = 1'b0;
        stall = 0;
        while (bus.ioctl_wait === 1'b1 && stall < 16) begin
            @(negedge clk_sys);
            stall++;
        end
        d = bus.ioctl_din;
        $display("rd addr=%h din=%h stall=%0d", a, d, stall);
    endtask

    task automatic pulse_trigger();
        save_trigger = 1'b1;
        @(negedge clk_sys);
        save_trigger = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        $display("trigger req_pulses=%0d", req_pulses);
    endtask

    initial begin
        logic [7:0] d;
        int         st;
        int         base;
        for (int i = 0; i < 32768; i++) ram[i] = 8'(i * 37 + 11);
        ram[16] = 8'hA5;
        mem_q            = 8'h00;
        reset_n          = 1'b0;
        save_trigger     = 1'b0;
        mem_we_mon       = 1'b0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd0;
        bus.ioctl_addr   = '0;
        bus.ioctl_rd     = 1'b0;

        repeat (2) @(negedge clk_sys);
        chk("rst_din", bus.ioctl_din, 8'h00);
        chk("rst_wait", bus.ioctl_wait, 1'b0);
        chk("rst_req", ioctl_upload_req, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_addr", mem_addr, 15'h0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Single read of 0x10, cycle by cycle
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = 8'd2;
        bus.ioctl_addr   = 25'h10;
        bus.ioctl_rd     = 1'b1;
        base = rd_pulses;
        @(negedge clk_sys);
        bus.ioctl_rd = 1'b0;
        chk("one_mem_rd_c1", mem_rd, 1'b1);
        chk("one_wait_c1", bus.ioctl_wait, 1'b1);
        chk("one_mem_addr", mem_addr, 15'h10);
        @(negedge clk_sys);
        chk("one_mem_rd_c2", mem_rd, 1'b0);
        chk("one_wait_c2", bus.ioctl_wait, 1'b1);
        @(negedge clk_sys);
        chk("one_wait_c3", bus.ioctl_wait, 1'b0);
        chk("one_din", bus.ioctl_din, 8'hA5);
        chk("one_pulses", rd_pulses, base + 1);
        $display("rd addr=%h din=%h single", 25'h10, bus.ioctl_din);

        // Sequential read 0..31
        base = rd_pulses;
        for (int i = 0; i < 32; i++) begin
            hps_read(25'(i), d, st);
            chk("seq_data", d, ram[i]);
            chk("seq_stall", st, 2);
        end
        chk("seq_pulses", rd_pulses, base + 32);

        // End of image and no wrap at 2^ADDR_W
        base = rd_pulses;
        hps_read(25'h8000, d, st);
        chk("fill_data", d, 8'hFF);
        chk("fill_stall", st, 0);
        hps_read(25'h10, d, st);
        chk("prewrap_data", d, 8'hA5);
        hps_read(25'h10010, d, st);
        chk("nowrap_data", d, 8'hFF);
        chk("fill_pulses", rd_pulses, base + 1);

        // Foreign index is ignored
        hps_read(25'h10, d, st);
        base = rd_pulses;
        bus.ioctl_index = 8'd1;
        hps_read(25'h8000, d, st);
        chk("idx_fill_din", d, 8'hA5);
        hps_read(25'h20, d, st);
        chk("idx_din", d, 8'hA5);
        chk("idx_stall", st, 0);
        chk("idx_pulses", rd_pulses, base);
        bus.ioctl_index = 8'd2;

        // Second rd while busy is ignored
        base = rd_pulses;
        bus.ioctl_addr = 25'h11;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_addr = 25'h20;
        @(negedge clk_sys);
        bus.ioctl_rd = 1'b0;
        @(negedge clk_sys);
        chk("viol_din", bus.ioctl_din, ram[17]);
        chk("viol_wait", bus.ioctl_wait, 1'b0);
        @(negedge clk_sys);
        chk("viol_pulses", rd_pulses, base + 1);
        $display("rd addr=%h din=%h overlapped", 25'h11, bus.ioctl_din);

        // Upload dropped mid-FETCH
        bus.ioctl_addr = 25'h12;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("abort_wait", bus.ioctl_wait, 1'b0);
        chk("abort_din", bus.ioctl_din, ram[17]);
        @(negedge clk_sys);
        chk("abort_din_hold", bus.ioctl_din, ram[17]);
        $display("rd addr=%h aborted din=%h", 25'h12, bus.ioctl_din);

        // Async reset mid-FETCH
        bus.ioctl_upload = 1'b1;
        bus.ioctl_addr   = 25'h10;
        bus.ioctl_rd     = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_rd = 1'b0;
        chk("rstmid_pre_rd", mem_rd, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_mem_rd", mem_rd, 1'b0);
        chk("rstmid_wait", bus.ioctl_wait, 1'b0);
        chk("rstmid_din", bus.ioctl_din, 8'h00);
        $display("reset asserted mid-fetch");
        @(negedge clk_sys);
        bus.ioctl_upload = 1'b0;
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Save request handshake
        base = req_pulses;
        pulse_trigger();
        chk("req_clean", req_pulses, base);
        mem_we_mon = 1'b1;
        @(negedge clk_sys);
        mem_we_mon   = 1'b0;
        save_trigger = 1'b1;
        @(negedge clk_sys);
        chk("req_level_hi", ioctl_upload_req, 1'b1);
        @(negedge clk_sys);
        chk("req_level_lo", ioctl_upload_req, 1'b0);
        save_trigger = 1'b0;
        @(negedge clk_sys);
        chk("req_first", req_pulses, base + 1);
        pulse_trigger();
        chk("req_no_repeat", req_pulses, base + 1);

        bus.ioctl_upload = 1'b1;
        repeat (3) @(negedge clk_sys);
        bus.ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        pulse_trigger();
        chk("req_after_upload", req_pulses, base + 1);

        bus.ioctl_upload = 1'b1;
        repeat (3) @(negedge clk_sys);
        bus.ioctl_upload = 1'b0;
        mem_we_mon       = 1'b1;
        @(negedge clk_sys);
        mem_we_mon = 1'b0;
        @(negedge clk_sys);
        pulse_trigger();
        chk("req_write_wins", req_pulses, base + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
